vga_fb_arbiter: RTL and testbench

- Arbitrates one single-port synchronous framebuffer RAM between two requesters: the display scan-out and a pixel writer (drawing engine or CPU bridge).
- Sits between the VGA timing generator and the RAM.
- The display has strict priority during active video. The writer is served only during blanking.
- Also generates the linear scan-out address and delays sync/DE so they align with the returned pixel data.

---
 rtl/vga_fb_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// vga_fb_arbiter
//
// Shares one single-port synchronous framebuffer RAM between the display
// scan-out and a pixel writer. The display always owns the RAM during active
// video; the writer is served only in blanking, one write per cycle. The block
// also generates the linear scan-out address and delays hsync/vsync/DE so they
// line up with the returned pixel data.
//
// Build option: define VGA_ARB_DBLBUF_EN for double buffering. The reader and
// writer then use opposite pages, and a requested page flip takes effect on the
// next falling edge of vsync_i. Without the macro the page bit is constant 0,
// swap_req_i is ignored and swap_ack_o is tied low.
//
// Ports:
//   clk_i, rst_n             pixel clock, asynchronous active-low reset
//   hsync_i, vsync_i         timing-generator syncs (active low)
//   pix_vld_i                active-video strobe
//   wr_valid_i/wr_ready_o    writer handshake; wr_addr_i, wr_data_i payload
//   swap_req_i/swap_ack_o    page-flip request / one-cycle flip pulse
//   mem_*                    RAM command (registered), mem_addr_o MSB = page
//   mem_rdata_i              RAM read data, sampled on the RD_LAT-th clock
//                            edge after the edge that launched mem_re_o
//   pix_data_o, hsync_o,
//   vsync_o, de_o            video out, 1+RD_LAT cycles after the inputs
// -----------------------------------------------------------------------------
module vga_fb_arbiter #(
  parameter int AW       = 19,
  parameter int DW       = 8,
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int RD_LAT   = 1
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic          hsync_i,
  input  logic          vsync_i,
  input  logic          pix_vld_i,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          swap_req_i,
  output logic          swap_ack_o,
  output logic [AW:0]   mem_addr_o,
  output logic          mem_we_o,
  output logic          mem_re_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic [DW-1:0] pix_data_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          de_o
);

  // Encoding chosen so the RAM strobes are plain state-register bits.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DISP  = 2'b01,
    ST_WRITE = 2'b10
  } state_e;

  // Last scan address of a frame; an elaboration-time constant.
  localparam logic [AW-1:0] SCAN_LAST = AW'(H_ACTIVE * V_ACTIVE - 1);

  state_e              state_q, state_d;
  logic [AW:0]         addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [AW-1:0]       scan_q, scan_d;
  logic [DW-1:0]       pix_q, pix_d;
  logic [RD_LAT:0]     hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic                rd_page, wr_page;

  // ---------------------------------------------------------------------------
  // Page selection
  // ---------------------------------------------------------------------------
`ifdef VGA_ARB_DBLBUF_EN
  logic rd_page_q, rd_page_d;
  logic pend_q, pend_d;
  logic vs_prev_q;
  logic ack_q, ack_d;
  logic vs_fall;

  assign vs_fall = vs_prev_q & ~vsync_i;

  always_comb begin
    // A request on the edge cycle itself is folded in before the edge test,
    // and any number of requests within a frame collapse into one flip.
    pend_d    = pend_q | swap_req_i;
    rd_page_d = rd_page_q;
    ack_d     = 1'b0;
    if (vs_fall && pend_d) begin
      rd_page_d = ~rd_page_q;
      pend_d    = 1'b0;
      ack_d     = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_page_q <= 1'b0;
      pend_q    <= 1'b0;
      vs_prev_q <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      rd_page_q <= rd_page_d;
      pend_q    <= pend_d;
      vs_prev_q <= vsync_i;
      ack_q     <= ack_d;
    end
  end

  assign rd_page    = rd_page_q;
  assign wr_page    = ~rd_page_q;
  assign swap_ack_o = ack_q;
`else
  logic unused_swap;

  assign unused_swap = swap_req_i;
  assign rd_page     = 1'b0;
  assign wr_page     = 1'b0;
  assign swap_ack_o  = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Arbitration, scan address and video delay lines
  // ---------------------------------------------------------------------------
  // The writer may only proceed outside active video, and never during reset.
  assign wr_ready_o = rst_n & ~pix_vld_i;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned;
    // otherwise synthesis infers a latch.
    state_d = ST_IDLE;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    scan_d  = scan_q;

    // Display strictly beats the writer; it is never stalled.
    if (pix_vld_i) begin
      state_d = ST_DISP;
      addr_d  = {rd_page, scan_q};
    end else if (wr_valid_i) begin
      state_d = ST_WRITE;
      addr_d  = {wr_page, wr_addr_i};
      wdata_d = wr_data_i;
    end

    if (!vsync_i) begin
      scan_d = '0;
    end else if (state_d == ST_DISP) begin
      scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + 1'b1;
    end

    // Bit 0 of each line is the newest sample; bit RD_LAT is the output.
    hs_d = {hs_q[RD_LAT-1:0], hsync_i};
    vs_d = {vs_q[RD_LAT-1:0], vsync_i};
    de_d = {de_q[RD_LAT-1:0], pix_vld_i};

    // de_q[RD_LAT-1] is the DE stage that lines up with mem_rdata_i.
    pix_d = de_q[RD_LAT-1] ? mem_rdata_i : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      scan_q  <= '0;
      pix_q   <= '0;
      hs_q    <= '1;
      vs_q    <= '1;
      de_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      scan_q  <= scan_d;
      pix_q   <= pix_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      de_q    <= de_d;
    end
  end

  assign mem_re_o    = state_q[0];
  assign mem_we_o    = state_q[1];
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign pix_data_o  = pix_q;
  assign hsync_o     = hs_q[RD_LAT];
  assign vsync_o     = vs_q[RD_LAT];
  assign de_o        = de_q[RD_LAT];

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_arbiter
//
// Directed bench for vga_fb_arbiter. The DUT runs with a reduced 16x6 active
// area (24x10 total timing) so whole frames and the scan-address wrap fit in a
// short run. The RAM model returns a fixed function of the read address during
// the cycle mem_re_o is high (RD_LAT = 1) and 8'hEE otherwise.
// Inputs are driven 1 ns after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_vga_fb_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;
  localparam int HA = 16;
  localparam int VA = 6;

`ifdef VGA_ARB_DBLBUF_EN
  localparam logic DBL = 1'b1;
`else
  localparam logic DBL = 1'b0;
`endif
  // Page used by writes right after reset.
  localparam logic WRPG = DBL;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic          hsync_i, vsync_i, pix_vld_i, wr_valid_i, wr_ready_o;
  logic [AW-1:0] wr_addr_i;
  logic [DW-1:0] wr_data_i;
  logic          swap_req_i, swap_ack_o;
  logic [AW:0]   mem_addr_o;
  logic          mem_we_o, mem_re_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i, pix_data_o;
  logic          hsync_o, vsync_o, de_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  vga_fb_arbiter #(
    .AW(AW), .DW(DW), .H_ACTIVE(HA), .V_ACTIVE(VA), .RD_LAT(1)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .hsync_i(hsync_i), .vsync_i(vsync_i), .pix_vld_i(pix_vld_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i),
    .swap_req_i(swap_req_i), .swap_ack_o(swap_ack_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_re_o(mem_re_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .pix_data_o(pix_data_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o)
  );

  function automatic logic [7:0] ram_f(input logic [19:0] a);
    return a[7:0] ^ a[15:8] ^ {a[19], 7'h00} ^ 8'h3C;
  endfunction

  assign mem_rdata_i = mem_re_o ? ram_f(mem_addr_o) : 8'hEE;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic vs, input logic hs, input logic pv, input logic wv,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    vsync_i = vs; hsync_i = hs; pix_vld_i = pv; wr_valid_i = wv;
    wr_addr_i = a; wr_data_i = d;
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic          vs, pv, wv;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          e_rdy;    // wr_ready_o in the same cycle
    logic          e_we;     // RAM command in the following cycle
    logic          e_re;
    logic [AW:0]   e_addr;
    logic [DW-1:0] e_wd;
  } vec_t;

  function automatic vec_t mk(input logic vs, input logic pv, input logic wv,
                              input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic rdy, input logic we, input logic re,
                              input logic [AW:0] ea, input logic [DW-1:0] ewd);
    vec_t v;
    v.vs = vs; v.pv = pv; v.wv = wv; v.wa = wa; v.wd = wd;
    v.e_rdy = rdy; v.e_we = we; v.e_re = re; v.e_addr = ea; v.e_wd = ewd;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int fe, pe, se, we_err, wrap_err, acks, ack_at;
    logic [AW:0] last_addr, first_addr, a95, a96;
    logic got_first;
    logic act_h[3], hs_h[3], vs_h[3];
    int addr_h[3];

    // ---------------- Reset with random inputs -------------------------------
    rst_n = 1'b0;
    swap_req_i = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            AW'($urandom), DW'($urandom));
      swap_req_i = 1'($urandom);
      #10;
    end
    @(negedge clk_i);
    check("rst_mem_addr", 32'(mem_addr_o), 0);
    check("rst_we_re", {mem_we_o, mem_re_o}, 0);
    check("rst_wdata", 32'(mem_wdata_o), 0);
    check("rst_pix_data", 32'(pix_data_o), 0);
    check("rst_sync_de", {hsync_o, vsync_o, de_o}, 32'b110);
    check("rst_swap_ack", 32'(swap_ack_o), 0);
    check("rst_wr_ready", 32'(wr_ready_o), 0);
    next_cycle();
    swap_req_i = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    @(negedge clk_i);
    check("post_rst_wr_ready", 32'(wr_ready_o), 1);
    next_cycle();

    // ---------------- Table-driven arbitration vectors ------------------------
    vecs[0]  = mk(0, 0, 0, '0,         '0,    1, 0, 0, '0,                     8'h00);
    vecs[1]  = mk(1, 0, 1, 19'h00100,  8'hA5, 1, 1, 0, {WRPG, 19'h00100},      8'hA5);
    vecs[2]  = mk(1, 0, 1, 19'h00101,  8'h5A, 1, 1, 0, {WRPG, 19'h00101},      8'h5A);
    vecs[3]  = mk(1, 1, 1, 19'h00102,  8'h33, 0, 0, 1, {1'b0, 19'd0},          8'h5A);
    vecs[4]  = mk(1, 1, 1, 19'h00102,  8'h33, 0, 0, 1, {1'b0, 19'd1},          8'h5A);
    vecs[5]  = mk(1, 1, 1, 19'h00102,  8'h33, 0, 0, 1, {1'b0, 19'd2},          8'h5A);
    vecs[6]  = mk(1, 0, 1, 19'h00102,  8'h33, 1, 1, 0, {WRPG, 19'h00102},      8'h33);
    vecs[7]  = mk(1, 0, 0, '0,         '0,    1, 0, 0, {WRPG, 19'h00102},      8'h33);
    vecs[8]  = mk(1, 0, 1, 19'h7FFFF,  8'hFF, 1, 1, 0, {WRPG, 19'h7FFFF},      8'hFF);
    vecs[9]  = mk(1, 1, 0, '0,         '0,    0, 0, 1, {1'b0, 19'd3},          8'hFF);
    vecs[10] = mk(0, 0, 0, '0,         '0,    1, 0, 0, {1'b0, 19'd3},          8'hFF);
    vecs[11] = mk(1, 1, 0, '0,         '0,    0, 0, 1, {1'b0, 19'd0},          8'hFF);

    for (int i = 0; i <= 12; i++) begin
      if (i < 12) drive(vecs[i].vs, 1'b1, vecs[i].pv, vecs[i].wv, vecs[i].wa, vecs[i].wd);
      else        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk_i);
      if (i < 12) check($sformatf("vec%0d_wr_ready", i), 32'(wr_ready_o), 32'(vecs[i].e_rdy));
      if (i > 0) begin
        check($sformatf("vec%0d_we_re", i-1), {mem_we_o, mem_re_o},
              {vecs[i-1].e_we, vecs[i-1].e_re});
        check($sformatf("vec%0d_addr", i-1), 32'(mem_addr_o), 32'(vecs[i-1].e_addr));
        check($sformatf("vec%0d_wdata", i-1), 32'(mem_wdata_o), 32'(vecs[i-1].e_wd));
      end
      next_cycle();
    end

    // ---------------- Scan-out: 4 active pixels ------------------------------
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    next_cycle();
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 1'b1, k < 4, 1'b0, '0, '0);
      @(negedge clk_i);
      check($sformatf("scan%0d_re", k), 32'(mem_re_o), 32'(k >= 1 && k <= 4));
      if (k >= 1 && k <= 4)
        check($sformatf("scan%0d_addr", k), 32'(mem_addr_o), k - 1);
      check($sformatf("scan%0d_de", k), 32'(de_o), 32'(k >= 2 && k <= 5));
      check($sformatf("scan%0d_pix", k), 32'(pix_data_o),
            (k >= 2 && k <= 5) ? 32'(ram_f({1'b0, 19'(k - 2)})) : 0);
      next_cycle();
    end

    // ---------------- Contention: write held across active video -------------
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, k < 3, k <= 3, 19'h00200, 8'h77);
      @(negedge clk_i);
      check($sformatf("cont%0d_ready", k), 32'(wr_ready_o), 32'(k >= 3));
      check($sformatf("cont%0d_we", k), 32'(mem_we_o), 32'(k == 4));
      if (k == 4) begin
        check("cont_addr", 32'(mem_addr_o), 32'({WRPG, 19'h00200}));
        check("cont_wdata", 32'(mem_wdata_o), 32'h77);
      end
      next_cycle();
    end

    // ---------------- Full frames, 24x10 timing ------------------------------
    fe = 0; pe = 0; se = 0; we_err = 0; got_first = 1'b0;
    last_addr = '0; first_addr = '1;
    for (int j = 0; j < 3; j++) begin
      act_h[j] = 1'b0; hs_h[j] = 1'b1; vs_h[j] = 1'b1; addr_h[j] = 0;
    end
    for (int f = 0; f < 3; f++) begin
      for (int v = 0; v < 10; v++) begin
        for (int h = 0; h < 24; h++) begin
          drive(!(v >= 7 && v < 9), !(h >= 18 && h < 21), (h < HA) && (v < VA), 1'b0, '0, '0);
          @(negedge clk_i);
          for (int j = 2; j > 0; j--) begin
            act_h[j] = act_h[j-1]; hs_h[j] = hs_h[j-1];
            vs_h[j] = vs_h[j-1]; addr_h[j] = addr_h[j-1];
          end
          act_h[0] = pix_vld_i; hs_h[0] = hsync_i; vs_h[0] = vsync_i;
          addr_h[0] = v * HA + h;
          if (f > 0) begin
            if (mem_re_o !== act_h[1]) fe++;
            if (act_h[1] && mem_addr_o !== 20'(addr_h[1])) fe++;
            if (mem_we_o !== 1'b0) we_err++;
            if (de_o !== act_h[2]) pe++;
            if (pix_data_o !== (act_h[2] ? ram_f(20'(addr_h[2])) : 8'h00)) pe++;
            if (hsync_o !== hs_h[2] || vsync_o !== vs_h[2]) se++;
          end
          if (f == 1 && mem_re_o) last_addr = mem_addr_o;
          if (f == 2 && mem_re_o && !got_first) begin
            first_addr = mem_addr_o;
            got_first  = 1'b1;
          end
          next_cycle();
        end
      end
    end
    check("frame_read_errors", fe, 0);
    check("frame_write_errors", we_err, 0);
    check("frame_pixel_errors", pe, 0);
    check("frame_sync_errors", se, 0);
    check("frame_last_addr", 32'(last_addr), HA * VA - 1);
    check("frame_first_addr", 32'(first_addr), 0);

    // ---------------- Scan-address wrap without vsync ------------------------
    drive(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    next_cycle();
    wrap_err = 0; a95 = '1; a96 = '1;
    for (int k = 0; k <= HA * VA + 2; k++) begin
      drive(1'b1, 1'b1, k < HA * VA + 2, 1'b0, '0, '0);
      @(negedge clk_i);
      if (k >= 1) begin
        if (mem_re_o !== 1'b1 || mem_addr_o !== 20'((k - 1) % (HA * VA))) wrap_err++;
      end
      if (k == HA * VA)     a95 = mem_addr_o;
      if (k == HA * VA + 1) a96 = mem_addr_o;
      next_cycle();
    end
    check("wrap_errors", wrap_err, 0);
    check("wrap_last", 32'(a95), HA * VA - 1);
    check("wrap_zero", 32'(a96), 0);

    // ---------------- Asynchronous reset mid-frame ---------------------------
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
      if (k < 2) next_cycle();
    end
    @(negedge clk_i);
    check("pre_rst_state", {mem_re_o, hsync_o, de_o}, 32'b101);
    #1;
    rst_n = 1'b0;
    pix_vld_i = 1'b0;
    #1;
    check("async_rst_outputs", {mem_re_o, mem_we_o, hsync_o, vsync_o, de_o, wr_ready_o},
          32'b001100);
    check("async_rst_addr", 32'(mem_addr_o), 0);
    check("async_rst_pix", 32'(pix_data_o), 0);
    next_cycle();
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    rst_n = 1'b1;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, k < 2, 1'b0, '0, '0);
      @(negedge clk_i);
      if (k >= 1) check($sformatf("post_rst_read%0d", k), {mem_re_o, 20'(mem_addr_o)},
                        {1'b1, 20'(k - 1)});
      next_cycle();
    end

    // ---------------- Page flip ----------------------------------------------
    acks = 0; ack_at = -1;
    for (int k = 0; k < 14; k++) begin
      swap_req_i = (k == 1 || k == 5);
      drive(!(k == 9 || k == 10), 1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk_i);
      if (swap_ack_o) begin
        acks++;
        ack_at = k;
      end
      next_cycle();
    end
    swap_req_i = 1'b0;
    check("swap_ack_count", acks, DBL ? 1 : 0);
    check("swap_ack_cycle", ack_at, DBL ? 10 : -1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 19'h00010, 8'h11);
    @(negedge clk_i);
    check("flip_read_page", {mem_re_o, mem_addr_o[AW]}, {1'b1, DBL});
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk_i);
    check("flip_write_addr", {mem_we_o, 20'(mem_addr_o)}, {1'b1, 20'h00010});
    next_cycle();

    // Request on the same cycle as the vsync fall is applied at that edge.
    acks = 0; ack_at = -1;
    for (int k = 0; k < 6; k++) begin
      swap_req_i = (k == 2);
      drive(!(k == 2), 1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk_i);
      if (swap_ack_o) begin
        acks++;
        ack_at = k;
      end
      next_cycle();
    end
    swap_req_i = 1'b0;
    check("edge_swap_count", acks, DBL ? 1 : 0);
    check("edge_swap_cycle", ack_at, DBL ? 3 : -1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, '0, '0);
    next_cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0);
    @(negedge clk_i);
    check("edge_read_page", {mem_re_o, mem_addr_o[AW]}, {1'b1, 1'b0});
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
